systolic_feeder: RTL and testbench

- Upstream stage of the systolic MAC array: accepts one A-column / B-row vector pair per beat over a valid/ready handshake.
- Skews the vectors diagonally so row i and column j enter the array i and j cycles late, keeping a_i,k and b_k,j aligned at PE(i,j).
- Drives the array's a_rows/b_columns inputs and generates tile control: accumulator clear at tile start, done pulse once the c_array result is final.

---
 rtl/systolic_pkg.sv | 24 ++
 rtl/skew_delay_line.sv | 37 +++
 rtl/systolic_feeder.sv | 131 +++++++++++++
 tb/tb_systolic_feeder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg : shared types and sizing for the systolic feeder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package systolic_pkg;

    localparam int unsigned systolic_size_c = 4;
    localparam int unsigned c_mac_data_w    = 16;

    typedef logic [c_mac_data_w-1:0]   t_mac_data;
    typedef logic [2*c_mac_data_w-1:0] t_mac_mul_data;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } t_feeder_state;

endpackage

`default_nettype wire

// File: rtl/skew_delay_line.sv
// ---------------------------------------------------------------------------
// skew_delay_line : depth_p-stage shift register of t_mac_data, async clear
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module skew_delay_line
    import systolic_pkg::*;
#(
    parameter int unsigned depth_p = 1
) (
    input  logic      clock_i,
    input  logic      reset_i,
    input  t_mac_data data_i,
    output t_mac_data data_o
);

    t_mac_data r_stage [depth_p];

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int s = 0; s < int'(depth_p); s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            r_stage[0] <= data_i;
            for (int s = 1; s < int'(depth_p); s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign data_o = r_stage[depth_p-1];

endmodule

`default_nettype wire

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder : diagonal operand skew and tile control for the MAC array
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned mac_latency_p = 1
) (
    input  logic                              clock_i,
    input  logic                              reset_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  logic                              last_i,
    input  t_mac_data [systolic_size_c-1:0]   a_vec_i,
    input  t_mac_data [systolic_size_c-1:0]   b_vec_i,
    output t_mac_data [systolic_size_c-1:0]   a_rows_o,
    output t_mac_data [systolic_size_c-1:0]   b_columns_o,
    output logic                              clear_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int unsigned c_drain_load = 2*systolic_size_c - 2 + mac_latency_p;
    localparam int unsigned c_cnt_w      = (c_drain_load < 2) ? 1 : $clog2(c_drain_load + 1);

    t_feeder_state                      r_state;
    t_feeder_state                      w_state_nxt;
    logic [c_cnt_w-1:0]                 r_cnt;
    logic [c_cnt_w-1:0]                 w_cnt_nxt;
    logic                               r_clear;
    logic                               w_clear_nxt;
    logic                               w_ready;
    logic                               w_accept;
    t_mac_data [systolic_size_c-1:0]    w_a_in;
    t_mac_data [systolic_size_c-1:0]    w_b_in;

    assign w_accept = valid_i && w_ready;

    // Idle cycles push zeros so bubbles contribute nothing yet keep alignment
    always_comb begin
        w_a_in = '0;
        w_b_in = '0;
        if (w_accept) begin
            w_a_in = a_vec_i;
            w_b_in = b_vec_i;
        end
    end

    generate
        for (genvar gi = 0; gi < systolic_size_c; gi++) begin : g_lane
            skew_delay_line #(.depth_p(gi + 1)) u_skew_a (
                .clock_i (clock_i),
                .reset_i (reset_i),
                .data_i  (w_a_in[gi]),
                .data_o  (a_rows_o[gi])
            );
            skew_delay_line #(.depth_p(gi + 1)) u_skew_b (
                .clock_i (clock_i),
                .reset_i (reset_i),
                .data_i  (w_b_in[gi]),
                .data_o  (b_columns_o[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_clear <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_clear <= w_clear_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clear_nxt = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (w_accept) begin
                    w_clear_nxt = 1'b1;
                    if (last_i) begin
                        w_state_nxt = ST_DRAIN;
                        w_cnt_nxt   = c_cnt_w'(c_drain_load);
                    end else begin
                        w_state_nxt = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                w_ready = 1'b1;
                if (w_accept && last_i) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = c_cnt_w'(c_drain_load);
                end
            end
            ST_DRAIN: begin
                // Leave on the cycle the count would reach zero so done lands on time
                if (r_cnt <= c_cnt_w'(1)) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - c_cnt_w'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ready_o = w_ready && !reset_i;
    assign clear_o = r_clear;
    assign busy_o  = (r_state != ST_IDLE);
    assign done_o  = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_feeder : directed bench with a behavioural output-stationary array
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_systolic_feeder;
    import systolic_pkg::*;

    localparam int N = systolic_size_c;
    typedef t_mac_data [N-1:0] vec_t;

    typedef struct {
        vec_t a_exp;
        vec_t b_exp;
        logic clr;
        logic dn;
        logic rdy;
        logic bsy;
    } rec_t;

    logic clock_i = 1'b0;
    logic reset_i;
    logic valid_i;
    logic last_i;
    vec_t a_vec_i;
    vec_t b_vec_i;
    vec_t a_rows_o;
    vec_t b_columns_o;
    logic ready_o;
    logic clear_o;
    logic busy_o;
    logic done_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_clear  = 0;
    int n_done   = 0;

    vec_t ta [8];
    vec_t tb_v [8];
    vec_t nxt_a;
    vec_t nxt_b;
    rec_t tbl [10];

    always #5 clock_i = ~clock_i;

    systolic_feeder #(.mac_latency_p(1)) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .last_i      (last_i),
        .a_vec_i     (a_vec_i),
        .b_vec_i     (b_vec_i),
        .a_rows_o    (a_rows_o),
        .b_columns_o (b_columns_o),
        .clear_o     (clear_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    // Output-stationary array: A moves right, B moves down, one-cycle product stage
    int    a_reg [N][N];
    int    b_reg [N][N];
    longint prod [N][N];
    longint acc  [N][N];

    function automatic int a_at(input int i, input int j);
        return (j == 0) ? int'(a_rows_o[i]) : a_reg[i][j-1];
    endfunction

    function automatic int b_at(input int i, input int j);
        return (i == 0) ? int'(b_columns_o[j]) : b_reg[i-1][j];
    endfunction

    always @(posedge clock_i) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a_reg[i][j] <= a_at(i, j);
                b_reg[i][j] <= b_at(i, j);
                prod[i][j]  <= longint'(a_at(i, j)) * longint'(b_at(i, j));
                acc[i][j]   <= clear_o ? 64'sd0 : acc[i][j] + prod[i][j];
            end
        end
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
        cyc++;
        if (clear_o) n_clear++;
        if (done_o)  n_done++;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic send_tile(input int n, input int gap_after, input int gap_len, input bit hold_next);
        int     t_last;
        int     waited;
        int     c0;
        int     d0;
        longint e;
        c0     = n_clear;
        d0     = n_done;
        t_last = 0;
        for (int k = 0; k < n; k++) begin
            valid_i = 1'b1;
            last_i  = (k == n - 1);
            a_vec_i = ta[k];
            b_vec_i = tb_v[k];
            waited  = 0;
            while (!ready_o && waited < 40) begin
                tick();
                waited++;
            end
            chk("beat_wait_bound", 64'(waited < 40), 64'd1);
            t_last = cyc;
            tick();
            if (k == 0) chk("tile_first_clear", 64'(clear_o), 64'd1);
            if (k == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    valid_i = 1'b0;
                    last_i  = 1'b1;
                    tick();
                    if (g == 0) begin
                        chk("bubble_a0", 64'(a_rows_o[0]), 64'd0);
                        chk("bubble_b0", 64'(b_columns_o[0]), 64'd0);
                        chk("gap_stream_ready", 64'(ready_o), 64'd1);
                    end
                end
            end
        end
        if (hold_next) begin
            valid_i = 1'b1;
            last_i  = 1'b0;
            a_vec_i = nxt_a;
            b_vec_i = nxt_b;
        end else begin
            valid_i = 1'b0;
            last_i  = 1'b0;
        end
        waited = 0;
        while (!done_o && waited < 40) begin
            chk("drain_ready_low", 64'(ready_o), 64'd0);
            tick();
            waited++;
        end
        chk("done_latency", 64'(cyc - t_last), 64'd8);
        tick();
        chk("done_one_cycle", 64'(done_o), 64'd0);
        chk("idle_ready", 64'(ready_o), 64'd1);
        chk("clears_per_tile", 64'(n_clear - c0), 64'd1);
        chk("dones_per_tile", 64'(n_done - d0), 64'd1);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                e = 0;
                for (int k = 0; k < n; k++) e += longint'(ta[k][i]) * longint'(tb_v[k][j]);
                chk($sformatf("c_%0d_%0d", i, j), acc[i][j], e);
            end
        end
    endtask

    initial begin
        int d0;
        reset_i = 1'b1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        a_vec_i = '0;
        b_vec_i = '0;

        for (int o = 0; o < 10; o++) begin
            tbl[o].a_exp = '0;
            tbl[o].b_exp = '0;
            tbl[o].clr   = (o == 1);
            tbl[o].dn    = (o == 8);
            tbl[o].rdy   = (o == 0 || o == 9);
            tbl[o].bsy   = (o > 0 && o < 9);
            if (o >= 1 && o <= 4) begin
                tbl[o].a_exp[o-1] = t_mac_data'(o);
                tbl[o].b_exp[o-1] = t_mac_data'(o + 4);
            end
        end

        // Reset state
        tick();
        tick();
        chk("rst_arows", a_rows_o, '0);
        chk("rst_bcols", b_columns_o, '0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_clear", 64'(clear_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        reset_i = 1'b0;
        #1;
        chk("ready_after_reset", 64'(ready_o), 64'd1);

        // Single K=1 beat, cycle-by-cycle table
        valid_i = 1'b1;
        last_i  = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_vec_i[i] = t_mac_data'(i + 1);
            b_vec_i[i] = t_mac_data'(i + 5);
        end
        for (int o = 0; o < 10; o++) begin
            if (o > 0) tick();
            if (o == 1) begin
                valid_i = 1'b0;
                last_i  = 1'b0;
            end
            chk($sformatf("v%0d_arows", o), a_rows_o, tbl[o].a_exp);
            chk($sformatf("v%0d_bcols", o), b_columns_o, tbl[o].b_exp);
            chk($sformatf("v%0d_clear", o), 64'(clear_o), 64'(tbl[o].clr));
            chk($sformatf("v%0d_done", o), 64'(done_o), 64'(tbl[o].dn));
            chk($sformatf("v%0d_ready", o), 64'(ready_o), 64'(tbl[o].rdy));
            chk($sformatf("v%0d_busy", o), 64'(busy_o), 64'(tbl[o].bsy));
        end

        // Asynchronous reset in the middle of DRAIN
        valid_i = 1'b1;
        last_i  = 1'b1;
        tick();
        valid_i = 1'b0;
        last_i  = 1'b0;
        tick();
        tick();
        chk("pre_rst_arow2", 64'(a_rows_o[2]), 64'd3);
        d0 = n_done;
        #2 reset_i = 1'b1;
        #1;
        chk("midrst_arows", a_rows_o, '0);
        chk("midrst_bcols", b_columns_o, '0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_ready", 64'(ready_o), 64'd0);
        chk("midrst_done", 64'(done_o), 64'd0);
        @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        #1;
        chk("midrst_ready_after", 64'(ready_o), 64'd1);
        repeat (12) tick();
        chk("midrst_no_done", 64'(n_done - d0), 64'd0);
        chk("midrst_idle", 64'(busy_o), 64'd0);

        // K=4 back-to-back, A = identity, B = 1..16
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) begin
                ta[k][i]   = t_mac_data'(i == k);
                tb_v[k][i] = t_mac_data'(4*k + i + 1);
            end
        end
        send_tile(4, -1, 0, 1'b0);
        chk("ident_c33", acc[3][3], 64'd16);

        // K=3 with a two-cycle gap after the first beat
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) begin
                ta[k][i]   = t_mac_data'(k + 2*i + 1);
                tb_v[k][i] = t_mac_data'(3*k + i + 2);
            end
        end
        send_tile(3, 0, 2, 1'b0);

        // Two tiles back-to-back, next beat held valid through DRAIN/DONE
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) begin
                ta[k][i]   = t_mac_data'(i*k + 1);
                tb_v[k][i] = t_mac_data'(k + i);
            end
        end
        for (int i = 0; i < N; i++) begin
            nxt_a[i] = t_mac_data'(7 + i);
            nxt_b[i] = t_mac_data'(9 - i);
        end
        send_tile(4, -1, 0, 1'b1);
        ta[0]   = nxt_a;
        tb_v[0] = nxt_b;
        for (int i = 0; i < N; i++) begin
            ta[1][i]   = t_mac_data'(2 + i);
            tb_v[1][i] = t_mac_data'(3*i + 1);
        end
        send_tile(2, -1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
